// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register of the five-stage RV32I core.
//
// Captures the decoded control bundle and the ID operands every rising edge
// and presents them to EX. The block also detects load-use hazards: it stalls
// PC and IF/ID for one cycle and injects a bubble into EX. A taken
// branch/jump resolved in EX (ex_flush) squashes the ID instruction and takes
// priority over a stall. Stall bubbles are counted in a saturating counter.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   id_*                decoded control, operands and register indices from ID
//   ex_flush            squash the instruction currently in ID
//   ex_*                registered copies of id_* for EX
//   ex_valid            EX holds a real instruction
//   pc_write            PC may advance (combinational)
//   if_id_write         IF/ID may load (combinational)
//   load_use_stall      load-use hazard this cycle (combinational)
//   bubble_count        saturating count of load-use bubbles
module id_ex_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [1:0]       id_alu_op,
  input  logic             id_alu_src,
  input  logic             id_ALUSrcA,
  input  logic             id_branch,
  input  logic             id_is_jal,
  input  logic             id_is_jalr,
  input  logic             id_is_lui,
  input  logic             id_is_sw,
  input  logic             id_is_lw,
  input  logic             id_MemRead,
  input  logic             id_MemWrite,
  input  logic             id_RegWrite,
  input  logic             id_MemtoReg,
  input  logic [XLEN-1:0]  id_pc,
  input  logic [XLEN-1:0]  id_rs1_data,
  input  logic [XLEN-1:0]  id_rs2_data,
  input  logic [XLEN-1:0]  id_imm,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic [2:0]       id_funct3,
  input  logic             id_funct7_5,
  input  logic             ex_flush,
  output logic             ex_valid,
  output logic [1:0]       ex_alu_op,
  output logic             ex_alu_src,
  output logic             ex_ALUSrcA,
  output logic             ex_branch,
  output logic             ex_is_jal,
  output logic             ex_is_jalr,
  output logic             ex_is_lui,
  output logic             ex_is_sw,
  output logic             ex_is_lw,
  output logic             ex_MemRead,
  output logic             ex_MemWrite,
  output logic             ex_RegWrite,
  output logic             ex_MemtoReg,
  output logic [XLEN-1:0]  ex_pc,
  output logic [XLEN-1:0]  ex_rs1_data,
  output logic [XLEN-1:0]  ex_rs2_data,
  output logic [XLEN-1:0]  ex_imm,
  output logic [4:0]       ex_rs1,
  output logic [4:0]       ex_rs2,
  output logic [4:0]       ex_rd,
  output logic [2:0]       ex_funct3,
  output logic             ex_funct7_5,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             load_use_stall,
  output logic [CNT_W-1:0] bubble_count
);

  logic w_rs1_used;
  logic w_rs2_used;
  logic w_hz;
  logic w_bubble;

  // Load-use hazard detection against the load currently in EX.
  always_comb begin
    // JAL/LUI/AUIPC-style (ALUSrcA) instructions do not read rs1; I-type
    // only reads rs2 when it is a store.
    w_rs1_used     = ~(id_is_jal | id_is_lui | id_ALUSrcA);
    w_rs2_used     = ~id_alu_src | id_is_sw;
    w_hz           = id_valid & ex_valid & ex_MemRead & (ex_rd != 5'd0) &
                     ((w_rs1_used & (id_rs1 == ex_rd)) |
                      (w_rs2_used & (id_rs2 == ex_rd)));
    // A flushed ID instruction is discarded, so it never needs to stall.
    load_use_stall = w_hz & ~ex_flush;
    pc_write       = ~load_use_stall;
    if_id_write    = ~load_use_stall;
    w_bubble       = ex_flush | load_use_stall;
  end

  // ID/EX pipeline register: bubble on flush or stall, otherwise capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || w_bubble) begin
      ex_valid    <= 1'b0;
      ex_alu_op   <= 2'b00;
      ex_alu_src  <= 1'b0;
      ex_ALUSrcA  <= 1'b0;
      ex_branch   <= 1'b0;
      ex_is_jal   <= 1'b0;
      ex_is_jalr  <= 1'b0;
      ex_is_lui   <= 1'b0;
      ex_is_sw    <= 1'b0;
      ex_is_lw    <= 1'b0;
      ex_MemRead  <= 1'b0;
      ex_MemWrite <= 1'b0;
      ex_RegWrite <= 1'b0;
      ex_MemtoReg <= 1'b0;
      ex_pc       <= {XLEN{1'b0}};
      ex_rs1_data <= {XLEN{1'b0}};
      ex_rs2_data <= {XLEN{1'b0}};
      ex_imm      <= {XLEN{1'b0}};
      ex_rs1      <= 5'd0;
      ex_rs2      <= 5'd0;
      ex_rd       <= 5'd0;
      ex_funct3   <= 3'd0;
      ex_funct7_5 <= 1'b0;
    end else begin
      // Control bits are masked by id_valid so an invalid slot in EX can
      // never write memory or the register file.
      ex_valid    <= id_valid;
      ex_alu_op   <= id_valid ? id_alu_op : 2'b00;
      ex_alu_src  <= id_valid & id_alu_src;
      ex_ALUSrcA  <= id_valid & id_ALUSrcA;
      ex_branch   <= id_valid & id_branch;
      ex_is_jal   <= id_valid & id_is_jal;
      ex_is_jalr  <= id_valid & id_is_jalr;
      ex_is_lui   <= id_valid & id_is_lui;
      ex_is_sw    <= id_valid & id_is_sw;
      ex_is_lw    <= id_valid & id_is_lw;
      ex_MemRead  <= id_valid & id_MemRead;
      ex_MemWrite <= id_valid & id_MemWrite;
      ex_RegWrite <= id_valid & id_RegWrite;
      ex_MemtoReg <= id_valid & id_MemtoReg;
      ex_pc       <= id_pc;
      ex_rs1_data <= id_rs1_data;
      ex_rs2_data <= id_rs2_data;
      ex_imm      <= id_imm;
      ex_rs1      <= id_rs1;
      ex_rs2      <= id_rs2;
      ex_rd       <= id_rd;
      ex_funct3   <= id_funct3;
      ex_funct7_5 <= id_funct7_5;
    end
  end

  // Saturating count of bubbles caused by load-use stalls (flushes excluded).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_count <= {CNT_W{1'b0}};
    end else if (load_use_stall && (bubble_count != {CNT_W{1'b1}})) begin
      bubble_count <= bubble_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      bubble_count <= bubble_count;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage, built with CNT_W = 2 so counter
// saturation is reachable with a handful of stalls.
module tb_id_ex_stage;
  localparam int XLEN  = 32;
  localparam int CNT_W = 2;

  logic clk, rst_n;
  logic id_valid, id_alu_src, id_ALUSrcA, id_branch, id_is_jal, id_is_jalr;
  logic id_is_lui, id_is_sw, id_is_lw, id_MemRead, id_MemWrite, id_RegWrite;
  logic id_MemtoReg, id_funct7_5, ex_flush;
  logic [1:0] id_alu_op;
  logic [XLEN-1:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic [2:0] id_funct3;

  logic ex_valid, ex_alu_src, ex_ALUSrcA, ex_branch, ex_is_jal, ex_is_jalr;
  logic ex_is_lui, ex_is_sw, ex_is_lw, ex_MemRead, ex_MemWrite, ex_RegWrite;
  logic ex_MemtoReg, ex_funct7_5;
  logic [1:0] ex_alu_op;
  logic [XLEN-1:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0] ex_rs1, ex_rs2, ex_rd;
  logic [2:0] ex_funct3;
  logic pc_write, if_id_write, load_use_stall;
  logic [CNT_W-1:0] bubble_count;

  int checks = 0;
  int errors = 0;
  logic [XLEN-1:0] rnd_pc, rnd_rs1d;

  id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_alu_op(id_alu_op),
    .id_alu_src(id_alu_src), .id_ALUSrcA(id_ALUSrcA), .id_branch(id_branch),
    .id_is_jal(id_is_jal), .id_is_jalr(id_is_jalr), .id_is_lui(id_is_lui),
    .id_is_sw(id_is_sw), .id_is_lw(id_is_lw), .id_MemRead(id_MemRead),
    .id_MemWrite(id_MemWrite), .id_RegWrite(id_RegWrite), .id_MemtoReg(id_MemtoReg),
    .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .id_imm(id_imm), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_funct3(id_funct3), .id_funct7_5(id_funct7_5), .ex_flush(ex_flush),
    .ex_valid(ex_valid), .ex_alu_op(ex_alu_op), .ex_alu_src(ex_alu_src),
    .ex_ALUSrcA(ex_ALUSrcA), .ex_branch(ex_branch), .ex_is_jal(ex_is_jal),
    .ex_is_jalr(ex_is_jalr), .ex_is_lui(ex_is_lui), .ex_is_sw(ex_is_sw),
    .ex_is_lw(ex_is_lw), .ex_MemRead(ex_MemRead), .ex_MemWrite(ex_MemWrite),
    .ex_RegWrite(ex_RegWrite), .ex_MemtoReg(ex_MemtoReg), .ex_pc(ex_pc),
    .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_funct3(ex_funct3),
    .ex_funct7_5(ex_funct7_5), .pc_write(pc_write), .if_id_write(if_id_write),
    .load_use_stall(load_use_stall), .bubble_count(bubble_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_id();
    id_valid = 1'b0; id_alu_op = 2'b00; id_alu_src = 1'b0; id_ALUSrcA = 1'b0;
    id_branch = 1'b0; id_is_jal = 1'b0; id_is_jalr = 1'b0; id_is_lui = 1'b0;
    id_is_sw = 1'b0; id_is_lw = 1'b0; id_MemRead = 1'b0; id_MemWrite = 1'b0;
    id_RegWrite = 1'b0; id_MemtoReg = 1'b0; id_pc = 32'h0; id_rs1_data = 32'h0;
    id_rs2_data = 32'h0; id_imm = 32'h0; id_rs1 = 5'd0; id_rs2 = 5'd0;
    id_rd = 5'd0; id_funct3 = 3'd0; id_funct7_5 = 1'b0;
  endtask

  task automatic set_lw(input logic [4:0] rd, input logic [4:0] rs1);
    clr_id();
    id_valid = 1'b1; id_alu_src = 1'b1; id_is_lw = 1'b1; id_MemRead = 1'b1;
    id_RegWrite = 1'b1; id_MemtoReg = 1'b1; id_rd = rd; id_rs1 = rs1;
    id_funct3 = 3'd2;
  endtask

  task automatic set_add(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    clr_id();
    id_valid = 1'b1; id_alu_op = 2'b10; id_RegWrite = 1'b1;
    id_rd = rd; id_rs1 = rs1; id_rs2 = rs2;
  endtask

  initial begin
    clk = 1'b0; rst_n = 1'b0; ex_flush = 1'b0;
    // Reset held with random operands in ID.
    clr_id();
    rnd_pc = $urandom; rnd_rs1d = $urandom;
    id_valid = 1'b1; id_MemRead = 1'b1; id_RegWrite = 1'b1; id_rd = 5'd9;
    id_pc = rnd_pc; id_rs1_data = rnd_rs1d; id_imm = $urandom;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
    chk("rst_ex_pc", ex_pc, 32'd0);
    chk("rst_ex_rd", {27'd0, ex_rd}, 32'd0);
    chk("rst_ex_RegWrite", {31'd0, ex_RegWrite}, 32'd0);
    chk("rst_ex_MemRead", {31'd0, ex_MemRead}, 32'd0);
    chk("rst_bubble_count", {30'd0, bubble_count}, 32'd0);
    chk("rst_pc_write", {31'd0, pc_write}, 32'd1);
    chk("rst_if_id_write", {31'd0, if_id_write}, 32'd1);

    // First edge after release captures ID.
    rst_n = 1'b1;
    step();
    chk("rel_ex_pc", ex_pc, rnd_pc);
    chk("rel_ex_rs1_data", ex_rs1_data, rnd_rs1d);
    chk("rel_ex_valid", {31'd0, ex_valid}, 32'd1);
    chk("rel_ex_rd", {27'd0, ex_rd}, 32'd9);
    chk("rel_ex_MemRead", {31'd0, ex_MemRead}, 32'd1);

    // ADDI x5, x1, 7 at pc 0x100 (EX holds load to x9, no dependency).
    clr_id();
    id_valid = 1'b1; id_alu_src = 1'b1; id_RegWrite = 1'b1; id_rd = 5'd5;
    id_rs1 = 5'd1; id_imm = 32'h7; id_pc = 32'h100;
    #1;
    chk("addi_no_stall", {31'd0, load_use_stall}, 32'd0);
    step();
    chk("addi_ex_rd", {27'd0, ex_rd}, 32'd5);
    chk("addi_ex_imm", ex_imm, 32'h7);
    chk("addi_ex_pc", ex_pc, 32'h100);
    chk("addi_ex_RegWrite", {31'd0, ex_RegWrite}, 32'd1);
    chk("addi_ex_valid", {31'd0, ex_valid}, 32'd1);
    chk("addi_ex_alu_src", {31'd0, ex_alu_src}, 32'd1);

    // lw x6, then add x7, x6, x1 -> one-cycle stall.
    set_lw(5'd6, 5'd2);
    step();
    set_add(5'd7, 5'd6, 5'd1);
    id_pc = 32'h108;
    #1;
    chk("lu_stall", {31'd0, load_use_stall}, 32'd1);
    chk("lu_pc_write", {31'd0, pc_write}, 32'd0);
    chk("lu_if_id_write", {31'd0, if_id_write}, 32'd0);
    step();
    chk("lu_bub_valid", {31'd0, ex_valid}, 32'd0);
    chk("lu_bub_RegWrite", {31'd0, ex_RegWrite}, 32'd0);
    chk("lu_bub_rd", {27'd0, ex_rd}, 32'd0);
    chk("lu_bub_pc", ex_pc, 32'd0);
    chk("lu_count1", {30'd0, bubble_count}, 32'd1);
    chk("lu_stall_clear", {31'd0, load_use_stall}, 32'd0);
    step();
    chk("lu_add_rd", {27'd0, ex_rd}, 32'd7);
    chk("lu_add_pc", ex_pc, 32'h108);
    chk("lu_add_valid", {31'd0, ex_valid}, 32'd1);
    chk("lu_count_hold", {30'd0, bubble_count}, 32'd1);

    // lw x0, then add x1, x0, x0 -> no stall.
    set_lw(5'd0, 5'd2);
    step();
    set_add(5'd1, 5'd0, 5'd0);
    #1;
    chk("x0_no_stall", {31'd0, load_use_stall}, 32'd0);
    step();
    chk("x0_captured", {27'd0, ex_rd}, 32'd1);

    // lw x6, then lui x6 (rs1 field 6 is not read).
    set_lw(5'd6, 5'd2);
    step();
    clr_id();
    id_valid = 1'b1; id_is_lui = 1'b1; id_alu_src = 1'b1; id_RegWrite = 1'b1;
    id_rd = 5'd6; id_rs1 = 5'd6;
    #1;
    chk("lui_no_stall", {31'd0, load_use_stall}, 32'd0);
    step();
    chk("lui_ex_is_lui", {31'd0, ex_is_lui}, 32'd1);

    // lw x6, then jal with rs1 field 6.
    set_lw(5'd6, 5'd2);
    step();
    clr_id();
    id_valid = 1'b1; id_is_jal = 1'b1; id_alu_src = 1'b1; id_RegWrite = 1'b1;
    id_rd = 5'd1; id_rs1 = 5'd6;
    #1;
    chk("jal_no_stall", {31'd0, load_use_stall}, 32'd0);
    step();
    chk("jal_ex_is_jal", {31'd0, ex_is_jal}, 32'd1);

    // lw x6, then addi x7, x1, 6 with rs2 field 6 (rs2 unused).
    set_lw(5'd6, 5'd2);
    step();
    clr_id();
    id_valid = 1'b1; id_alu_src = 1'b1; id_RegWrite = 1'b1;
    id_rd = 5'd7; id_rs1 = 5'd1; id_rs2 = 5'd6; id_imm = 32'h6;
    #1;
    chk("addi_rs2_no_stall", {31'd0, load_use_stall}, 32'd0);
    step();

    // lw x6, then sw x6, 0(x1): rs2 is read by a store -> stall.
    set_lw(5'd6, 5'd2);
    step();
    clr_id();
    id_valid = 1'b1; id_alu_src = 1'b1; id_is_sw = 1'b1; id_MemWrite = 1'b1;
    id_rs1 = 5'd1; id_rs2 = 5'd6;
    #1;
    chk("sw_stall", {31'd0, load_use_stall}, 32'd1);
    step();
    chk("sw_count2", {30'd0, bubble_count}, 32'd2);
    step();
    chk("sw_ex_MemWrite", {31'd0, ex_MemWrite}, 32'd1);

    // Flush and load-use in the same cycle: flush wins, no stall counted.
    set_lw(5'd6, 5'd2);
    step();
    set_add(5'd7, 5'd6, 5'd1);
    ex_flush = 1'b1;
    #1;
    chk("fl_no_stall", {31'd0, load_use_stall}, 32'd0);
    chk("fl_pc_write", {31'd0, pc_write}, 32'd1);
    step();
    ex_flush = 1'b0;
    chk("fl_bub_valid", {31'd0, ex_valid}, 32'd0);
    chk("fl_bub_RegWrite", {31'd0, ex_RegWrite}, 32'd0);
    chk("fl_count_same", {30'd0, bubble_count}, 32'd2);

    // Invalid ID slot with nonzero control: control masked, data captured.
    clr_id();
    id_RegWrite = 1'b1; id_MemRead = 1'b1; id_pc = 32'h200;
    step();
    chk("inv_ex_valid", {31'd0, ex_valid}, 32'd0);
    chk("inv_ex_RegWrite", {31'd0, ex_RegWrite}, 32'd0);
    chk("inv_ex_MemRead", {31'd0, ex_MemRead}, 32'd0);
    chk("inv_ex_pc", ex_pc, 32'h200);

    // Back-to-back dependent loads, each one bubble; counter saturates at 3.
    set_lw(5'd6, 5'd2);
    step();
    set_lw(5'd8, 5'd6);
    #1;
    chk("b2b1_stall", {31'd0, load_use_stall}, 32'd1);
    step();
    chk("sat_count3", {30'd0, bubble_count}, 32'd3);
    step();
    chk("b2b1_ex_rd", {27'd0, ex_rd}, 32'd8);
    set_lw(5'd9, 5'd8);
    #1;
    chk("b2b2_stall", {31'd0, load_use_stall}, 32'd1);
    step();
    chk("sat_count3b", {30'd0, bubble_count}, 32'd3);
    step();
    set_add(5'd10, 5'd9, 5'd1);
    #1;
    chk("b2b3_stall", {31'd0, load_use_stall}, 32'd1);
    step();
    chk("sat_count3c", {30'd0, bubble_count}, 32'd3);
    step();
    chk("b2b3_ex_rd", {27'd0, ex_rd}, 32'd10);

    // Reset asserted in the middle of a stall.
    set_lw(5'd6, 5'd2);
    step();
    set_add(5'd7, 5'd6, 5'd1);
    #1;
    chk("mid_stall", {31'd0, load_use_stall}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_stall", {31'd0, load_use_stall}, 32'd0);
    chk("mid_rst_pc_write", {31'd0, pc_write}, 32'd1);
    chk("mid_rst_valid", {31'd0, ex_valid}, 32'd0);
    chk("mid_rst_rd", {27'd0, ex_rd}, 32'd0);
    chk("mid_rst_count", {30'd0, bubble_count}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
